// File: rtl/bcrypt_output_collector_if.sv
// Proxy-side serial result lines plus the consumer FIFO read port of the output collector.
interface bcrypt_output_collector_if #(
  parameter int NUM_PROXY = 4
);
  logic [NUM_PROXY-1:0] proxy_empty;
  logic [NUM_PROXY-1:0] proxy_rd_en;
  logic [NUM_PROXY-1:0] proxy_dout;
  logic                 rd_en;
  logic                 empty;
  logic [15:0]          dout;
  logic                 timeout_err;

  // master: the collector itself; slave: proxies and consumer around it
  modport master (
    input  proxy_empty, proxy_dout, rd_en,
    output proxy_rd_en, empty, dout, timeout_err
  );
  modport slave (
    output proxy_empty, proxy_dout, rd_en,
    input  proxy_rd_en, empty, dout, timeout_err
  );
endinterface

// File: rtl/bcrypt_output_collector.sv
// Round-robin poller of serial proxy results; deserializes one packet into a word buffer read as a FIFO.
// Optional BCRYPT_OUTPUT_CHECKSUM_EN appends an XOR-of-all-words checksum word to every packet.
module bcrypt_output_collector #(
  parameter int NUM_PROXY     = 4,
  parameter int PKT_WORDS     = 4,
  parameter int START_TIMEOUT = 16
) (
  input  logic                        CLK,
  input  logic                        rst,
  bcrypt_output_collector_if.master   bus
);
  localparam int NBITS = 16 * PKT_WORDS;
  localparam int BCW   = $clog2(NBITS);
`ifdef BCRYPT_OUTPUT_CHECKSUM_EN
  localparam int BUF_WORDS = PKT_WORDS + 1;
`else
  localparam int BUF_WORDS = PKT_WORDS;
`endif
  localparam int WCW  = (BUF_WORDS > 1) ? $clog2(BUF_WORDS) : 1;
  localparam int SELW = (NUM_PROXY > 1) ? $clog2(NUM_PROXY) : 1;
  localparam int TCW  = $clog2(START_TIMEOUT);

  typedef enum logic [2:0] {S_SCAN, S_REQ, S_WAIT, S_SHIFT, S_OUT} state_e;

  state_e               state_q;
  logic [SELW-1:0]      sel_q;
  logic [NUM_PROXY-1:0] prd_en_q;
  logic                 empty_q;
  logic                 tmo_err_q;
  logic [TCW-1:0]       tmo_cnt_q;
  logic [BCW-1:0]       bit_cnt_q;
  logic [WCW-1:0]       word_cnt_q;
  logic [WCW-1:0]       rd_ptr_q;
  logic [15:0]          shreg_q;
  logic [15:0]          buf_q [BUF_WORDS];
`ifdef BCRYPT_OUTPUT_CHECKSUM_EN
  logic [15:0]          csum_q;
`endif

  logic            din;
  logic [15:0]     shreg_d;
  logic [SELW-1:0] sel_d;

  assign din     = bus.proxy_dout[sel_q];
  assign shreg_d = {din, shreg_q[15:1]};
  assign sel_d   = (sel_q == SELW'(NUM_PROXY - 1)) ? '0 : sel_q + 1'b1;

  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q    <= S_SCAN;
      sel_q      <= '0;
      prd_en_q   <= '0;
      empty_q    <= 1'b1;
      tmo_err_q  <= 1'b0;
      tmo_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      word_cnt_q <= '0;
      rd_ptr_q   <= '0;
      shreg_q    <= '0;
`ifdef BCRYPT_OUTPUT_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      prd_en_q <= '0;
      case (state_q)
        S_SCAN: begin
          if (!bus.proxy_empty[sel_q]) begin
            state_q  <= S_REQ;
            prd_en_q <= NUM_PROXY'(1) << sel_q;
          end else begin
            sel_q <= sel_d;
          end
        end
        S_REQ: begin
          tmo_cnt_q <= '0;
          state_q   <= S_WAIT;
`ifdef BCRYPT_OUTPUT_CHECKSUM_EN
          csum_q    <= '0;
`endif
        end
        S_WAIT: begin
          // a start bit on the limit cycle still wins over the timeout
          if (din) begin
            bit_cnt_q <= '0;
            state_q   <= S_SHIFT;
          end else if (tmo_cnt_q == TCW'(START_TIMEOUT - 1)) begin
            tmo_err_q <= 1'b1;
            sel_q     <= sel_d;
            state_q   <= S_SCAN;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
          end
        end
        S_SHIFT: begin
          shreg_q   <= shreg_d;
          bit_cnt_q <= bit_cnt_q + 1'b1;
          if (bit_cnt_q[3:0] == 4'hF) begin
            buf_q[word_cnt_q] <= shreg_d;
            word_cnt_q        <= word_cnt_q + 1'b1;
`ifdef BCRYPT_OUTPUT_CHECKSUM_EN
            csum_q            <= csum_q ^ shreg_d;
`endif
          end
          if (bit_cnt_q == BCW'(NBITS - 1)) begin
            bit_cnt_q  <= '0;
            word_cnt_q <= '0;
            empty_q    <= 1'b0;
            state_q    <= S_OUT;
`ifdef BCRYPT_OUTPUT_CHECKSUM_EN
            buf_q[PKT_WORDS] <= csum_q ^ shreg_d;
`endif
          end
        end
        S_OUT: begin
          // empty_q is low throughout OUT, so every rd_en here is a real pop
          if (bus.rd_en) begin
            if (rd_ptr_q == WCW'(BUF_WORDS - 1)) begin
              rd_ptr_q <= '0;
              empty_q  <= 1'b1;
              sel_q    <= sel_d;
              state_q  <= S_SCAN;
            end else begin
              rd_ptr_q <= rd_ptr_q + 1'b1;
            end
          end
        end
        default: state_q <= S_SCAN;
      endcase
    end
  end

  assign bus.proxy_rd_en = prd_en_q;
  assign bus.empty       = empty_q;
  assign bus.dout        = empty_q ? 16'h0000 : buf_q[rd_ptr_q];
  assign bus.timeout_err = tmo_err_q;
endmodule

// File: tb/tb_bcrypt_output_collector.sv
// Randomized bench for bcrypt_output_collector: proxy/consumer model with a word-queue scoreboard.
module tb_bcrypt_output_collector;
  localparam int NP = 4;
  localparam int PW = 4;
  localparam int NB = 16 * PW;
  localparam int ST = 16;

  logic CLK = 1'b0;
  logic rst = 1'b1;
  always #5 CLK = ~CLK;

  bcrypt_output_collector_if #(.NUM_PROXY(NP)) bus ();
  bcrypt_output_collector #(.NUM_PROXY(NP), .PKT_WORDS(PW), .START_TIMEOUT(ST)) dut (
    .CLK (CLK),
    .rst (rst),
    .bus (bus)
  );

  logic [NP-1:0] pend = '0;
  logic [NP-1:0] line = '0;
  logic          rd   = 1'b0;
  assign bus.proxy_empty = ~pend;
  assign bus.proxy_dout  = line;
  assign bus.rd_en       = rd;

  int          vecs = 0, errs = 0;
  logic [15:0] pw [NP][PW];
  int          pd [NP];
  logic [15:0] avail[$];
  logic [15:0] popped[$];
  int          served[$];
  bit          exp_tmo = 1'b0, busy = 1'b0, chk_on = 1'b0;
  int          last_srv = -1, rd_prob = 100, cur_bit = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // scoreboard: word queue becomes visible once the last serial bit has been sampled
  initial forever begin
    @(negedge CLK);
    if (chk_on) begin
      chk("empty", bus.empty, avail.size() == 0);
      if (avail.size() > 0) chk("dout", bus.dout, avail[0]);
      chk("timeout_err", bus.timeout_err, exp_tmo);
      if (avail.size() > 0 && bus.proxy_rd_en != '0) chk("rd_en_while_out", bus.proxy_rd_en, 0);
      if (rd && avail.size() > 0) popped.push_back(avail.pop_front());
    end
  end

  initial forever begin
    @(posedge CLK); #1;
    rd = ($urandom_range(99) < rd_prob);
  end

  task automatic serve();
    int p = 0, nhot = 0, ex = 0;
    logic [15:0] x;
    for (int i = 0; i < NP; i++) if (bus.proxy_rd_en[i]) begin p = i; nhot++; end
    chk("rd_en_onehot", nhot, 1);
    chk("rd_en_pending", pend[p], 1);
    if (last_srv >= 0) begin
      for (int k = 1; k <= NP; k++) begin
        ex = (last_srv + k) % NP;
        if (pend[ex]) break;
      end
      chk("rr_order", p, ex);
    end
    served.push_back(p);
    pend[p] = 1'b0; busy = 1'b1; last_srv = p;
    @(posedge CLK); #1;
    if (rst) begin line = '0; busy = 1'b0; return; end
    chk("rd_en_pulse", bus.proxy_rd_en, 0);
    for (int i = 0; i < pd[p] && i < ST; i++) begin
      line[p] = 1'b0;
      @(posedge CLK); #1;
      if (rst) begin line = '0; busy = 1'b0; return; end
    end
    if (pd[p] >= ST) begin exp_tmo = 1'b1; busy = 1'b0; return; end
    line[p] = 1'b1;
    @(posedge CLK); #1;
    if (rst) begin line = '0; busy = 1'b0; return; end
    for (int b = 0; b < NB; b++) begin
      cur_bit = b;
      line[p] = pw[p][b / 16][b % 16];
      @(posedge CLK); #1;
      if (rst) begin line = '0; busy = 1'b0; cur_bit = -1; return; end
    end
    line[p] = 1'b0; cur_bit = -1;
    x = '0;
    for (int w = 0; w < PW; w++) begin avail.push_back(pw[p][w]); x ^= pw[p][w]; end
`ifdef BCRYPT_OUTPUT_CHECKSUM_EN
    avail.push_back(x);
`endif
    busy = 1'b0;
  endtask

  initial forever begin
    @(negedge CLK);
    if (!rst && bus.proxy_rd_en != '0) serve();
  end

  task automatic do_reset(input int cyc);
    @(negedge CLK); rst = 1'b1;
    @(posedge CLK); #1;
    avail.delete(); exp_tmo = 1'b0; pend = '0; line = '0; last_srv = NP - 1;
    repeat (cyc - 1) @(posedge CLK);
    #1; rst = 1'b0;
  endtask

  task automatic load(input int p, input logic [15:0] w0, w1, w2, w3, input int d);
    pw[p][0] = w0; pw[p][1] = w1; pw[p][2] = w2; pw[p][3] = w3; pd[p] = d;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while ((pend != '0 || busy || avail.size() != 0) && n < budget) begin
      @(posedge CLK); #1; n++;
    end
    chk(name, (pend != '0 || busy || avail.size() != 0), 0);
    repeat (2) @(posedge CLK);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [NP-1:0] mask;
    do_reset(3);
    chk_on = 1'b1;
    @(negedge CLK);
    chk("rst_empty", bus.empty, 1);
    chk("rst_dout", bus.dout, 0);
    chk("rst_rd_en", bus.proxy_rd_en, 0);
    chk("rst_tmo", bus.timeout_err, 0);

    // proxy 2, words 1..4, rd_en held high before and through the packet
    rd_prob = 100; popped.delete(); served.delete();
    load(2, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 3);
    pend = 4'b0100;
    wait_done("done_a", 2000);
    chk("a_served", served[0], 2);
    chk("a_count", popped.size(), PW + ((avail.size() == 0) ? 0 : 0)
`ifdef BCRYPT_OUTPUT_CHECKSUM_EN
      + 1
`endif
    );
    for (int i = 0; i < PW; i++) chk("a_word", popped[i], i + 1);
`ifdef BCRYPT_OUTPUT_CHECKSUM_EN
    chk("a_csum", popped[PW], 16'h0004);
`endif

    // proxies 1 and 3 after reset: 1 first, then 3
    do_reset(2);
    rd_prob = 50; served.delete();
    load(1, $urandom, $urandom, $urandom, $urandom, 0);
    load(3, $urandom, $urandom, $urandom, $urandom, 7);
    pend = 4'b1010;
    wait_done("done_b", 3000);
    chk("b_n", served.size(), 2);
    chk("b_first", served[0], 1);
    chk("b_second", served[1], 3);

    // start bit withheld: sticky timeout, nothing delivered
    do_reset(2);
    popped.delete();
    load(0, $urandom, $urandom, $urandom, $urandom, ST);
    pend = 4'b0001;
    wait_done("done_tmo", 2000);
    @(negedge CLK);
    chk("tmo_set", bus.timeout_err, 1);
    chk("tmo_empty", bus.empty, 1);
    chk("tmo_nopop", popped.size(), 0);

    // start bit on the limit cycle is accepted
    do_reset(2);
    popped.delete();
    load(3, 16'hA5A5, 16'h5A5A, 16'h0F0F, 16'hF0F0, ST - 1);
    pend = 4'b1000;
    wait_done("done_lim", 2000);
    @(negedge CLK);
    chk("lim_tmo", bus.timeout_err, 0);
    chk("lim_w0", popped[0], 16'hA5A5);
    chk("lim_w3", popped[3], 16'hF0F0);

`ifdef BCRYPT_OUTPUT_CHECKSUM_EN
    do_reset(2);
    popped.delete();
    load(0, 16'h00FF, 16'h0F0F, 16'h1234, 16'hFFFF, 1);
    pend = 4'b0001;
    wait_done("done_csum", 2000);
    chk("csum_word", popped[PW], 16'hE23B);
`endif

    // reset in the middle of a packet, then sel restarts at 0
    do_reset(2);
    load(1, $urandom, $urandom, $urandom, $urandom, 2);
    pend = 4'b0010;
    n = 0;
    while (cur_bit < 20 && n < 500) begin @(posedge CLK); #1; n++; end
    chk("mid_reach", cur_bit >= 20, 1);
    do_reset(2);
    @(negedge CLK);
    chk("mid_empty", bus.empty, 1);
    chk("mid_rd_en", bus.proxy_rd_en, 0);
    served.delete();
    load(0, $urandom, $urandom, $urandom, $urandom, 4);
    load(3, $urandom, $urandom, $urandom, $urandom, 5);
    pend = 4'b1001;
    wait_done("done_mid", 3000);
    chk("mid_first", served[0], 0);
    chk("mid_second", served[1], 3);

    // randomized rounds of simultaneous requests
    for (int r = 0; r < 30; r++) begin
      if (r % 6 == 0) do_reset(2);
      else last_srv = -1;
      rd_prob = $urandom_range(10, 100);
      mask = NP'($urandom_range(1, (1 << NP) - 1));
      for (int p = 0; p < NP; p++) begin
        for (int w = 0; w < PW; w++) pw[p][w] = 16'($urandom);
        pd[p] = ($urandom_range(9) == 0) ? ST + int'($urandom_range(2)) : int'($urandom_range(ST - 1));
      end
      pend = mask;
      wait_done("done_rand", 6000);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
